// File: rtl/icache_ctrl_nway_if.sv
// Handshake/bus bundle for the N-way instruction cache controller.
// Modport "master" is the controller; "slave" is the fetch stage, tag/data
// arrays and read channel that surround it.
//   Read-address channel: o_arvalid rises and stays high until a cycle where
//   i_arready is also high; that cycle is the transfer. Read-data channel:
//   a beat transfers in any cycle where i_rvalid and o_rready are both high.
// Optional performance counters appear only when ICACHE_PERF_CNT_EN is defined.
interface icache_ctrl_nway_if #(
    parameter int WAYS  = 4,
    parameter int SETS  = 64,
    parameter int BEATS = 8
);
    localparam int WW = (WAYS  > 1) ? $clog2(WAYS)  : 1;
    localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int IW = $clog2(SETS);

    logic            i_start;
    logic            i_flush;
    logic [WAYS-1:0] i_valid;
    logic [WAYS-1:0] i_tag_match;
    logic            i_arready;
    logic            i_rvalid;
    logic            i_r_last;

    logic            o_stall;
    logic            o_hit;
    logic [WW-1:0]   o_hit_way;
    logic            o_arvalid;
    logic            o_rready;
    logic            o_fill_we;
    logic [WW-1:0]   o_fill_way;
    logic [BW-1:0]   o_beat_cnt;
    logic            o_fill_done;
    logic            o_refill_err;
    logic            o_inval_we;
    logic [IW-1:0]   o_inval_idx;
    logic            o_busy;
    logic [2:0]      o_state;     // debug view of the controller FSM
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0]     o_hit_cnt;
    logic [31:0]     o_miss_cnt;
    logic [15:0]     o_flush_cnt;
`endif

    modport master (
        input  i_start, i_flush, i_valid, i_tag_match, i_arready, i_rvalid, i_r_last,
        output o_stall, o_hit, o_hit_way, o_arvalid, o_rready, o_fill_we, o_fill_way,
               o_beat_cnt, o_fill_done, o_refill_err, o_inval_we, o_inval_idx, o_busy,
               o_state
`ifdef ICACHE_PERF_CNT_EN
        , output o_hit_cnt, o_miss_cnt, o_flush_cnt
`endif
    );

    modport slave (
        output i_start, i_flush, i_valid, i_tag_match, i_arready, i_rvalid, i_r_last,
        input  o_stall, o_hit, o_hit_way, o_arvalid, o_rready, o_fill_we, o_fill_way,
               o_beat_cnt, o_fill_done, o_refill_err, o_inval_we, o_inval_idx, o_busy,
               o_state
`ifdef ICACHE_PERF_CNT_EN
        , input o_hit_cnt, o_miss_cnt, o_flush_cnt
`endif
    );
endinterface

// File: rtl/icache_ctrl_nway.sv
// Control FSM for an N-way set-associative instruction cache.
// Resolves per-way hits, picks a refill victim (first invalid way, otherwise
// round-robin), issues the line read, counts refill beats and walks every set
// on an invalidate-all (fence.i). Outputs are decoded from state, counters
// and inputs in the same cycle.
// Optional: define ICACHE_PERF_CNT_EN to add saturating hit/miss/flush counters.
module icache_ctrl_nway #(
    parameter int WAYS  = 4,
    parameter int SETS  = 64,
    parameter int BEATS = 8
) (
    input logic                clk,
    input logic                arstn,
    icache_ctrl_nway_if.master bus
);
    localparam int WW = (WAYS  > 1) ? $clog2(WAYS)  : 1;
    localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int IW = $clog2(SETS);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        COMPARE_TAG = 3'd1,
        ADDR_REQ    = 3'd2,
        ALLOCATE    = 3'd3,
        FLUSH       = 3'd4
    } state_t;

    state_t          state;
    logic [BW-1:0]   beat_cnt;
    logic [IW-1:0]   flush_idx;
    logic [WW-1:0]   rr_ptr;
    logic [WW-1:0]   victim;
    logic            flush_pend;

    logic [WAYS-1:0] hit_vec;
    logic            hit_any;
    logic [WW-1:0]   hit_idx;
    logic            any_free;
    logic [WW-1:0]   free_idx;
    logic [WW-1:0]   rr_next;
    logic [BW-1:0]   beat_next;
    logic            beat_xfer;
    logic            last_xfer;

    assign hit_vec   = bus.i_valid & bus.i_tag_match;
    assign rr_next   = (rr_ptr == WW'(WAYS - 1)) ? '0 : rr_ptr + 1'b1;
    assign beat_next = (beat_cnt == BW'(BEATS - 1)) ? '0 : beat_cnt + 1'b1;
    assign beat_xfer = (state == ALLOCATE) && bus.i_rvalid;
    assign last_xfer = beat_xfer && bus.i_r_last;

    // Lowest-index hitting way wins; multiple hits are illegal anyway.
    always_comb begin
        hit_any = |hit_vec;
        hit_idx = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (hit_vec[w]) hit_idx = WW'(w);
        end
    end

    // Lowest-index invalid way is the preferred victim.
    always_comb begin
        any_free = ~&bus.i_valid;
        free_idx = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!bus.i_valid[w]) free_idx = WW'(w);
        end
    end

    // Main controller FSM with its counters, victim and flush bookkeeping.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            flush_idx  <= '0;
            rr_ptr     <= '0;
            victim     <= '0;
            flush_pend <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush_pend || bus.i_flush) state <= FLUSH;
                    else if (bus.i_start)          state <= COMPARE_TAG;
                end
                COMPARE_TAG: begin
                    if (bus.i_flush) flush_pend <= 1'b1;
                    if (hit_any) begin
                        state <= IDLE;
                    end else begin
                        if (any_free) begin
                            victim <= free_idx;
                        end else begin
                            victim <= rr_ptr;
                            rr_ptr <= rr_next;
                        end
                        state <= ADDR_REQ;
                    end
                end
                ADDR_REQ: begin
                    if (bus.i_flush) flush_pend <= 1'b1;
                    if (bus.i_arready) begin
                        beat_cnt <= '0;
                        state    <= ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    if (bus.i_flush) flush_pend <= 1'b1;
                    if (bus.i_rvalid) begin
                        beat_cnt <= beat_next;
                        if (bus.i_r_last) state <= COMPARE_TAG;
                    end
                end
                FLUSH: begin
                    if (flush_idx == IW'(SETS - 1)) begin
                        flush_idx  <= '0;
                        flush_pend <= 1'b0;
                        rr_ptr     <= '0;
                        state      <= IDLE;
                    end else begin
                        flush_idx <= flush_idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output decode from state, counters and current inputs.
    always_comb begin
        bus.o_stall      = !((state == COMPARE_TAG) && hit_any);
        bus.o_hit        = (state == COMPARE_TAG) && hit_any;
        bus.o_hit_way    = (state == COMPARE_TAG) ? hit_idx : '0;
        bus.o_arvalid    = (state == ADDR_REQ);
        bus.o_rready     = (state == ALLOCATE);
        bus.o_fill_we    = beat_xfer;
        bus.o_fill_way   = victim;
        bus.o_beat_cnt   = beat_cnt;
        bus.o_fill_done  = last_xfer;
        bus.o_refill_err = last_xfer && (beat_cnt != BW'(BEATS - 1));
        bus.o_inval_we   = (state == FLUSH);
        bus.o_inval_idx  = flush_idx;
        bus.o_busy       = (state != IDLE);
        bus.o_state      = state;
    end

`ifdef ICACHE_PERF_CNT_EN
    logic        refill_cmp;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
    logic [15:0] flush_cnt;

    // Saturating event counters; the compare that follows a refill is not a hit.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            refill_cmp <= 1'b0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
            flush_cnt  <= '0;
        end else begin
            if (last_xfer)                  refill_cmp <= 1'b1;
            else if (state == COMPARE_TAG)  refill_cmp <= 1'b0;
            if ((state == COMPARE_TAG) && hit_any && !refill_cmp && (hit_cnt != '1))
                hit_cnt <= hit_cnt + 1'b1;
            if ((state == COMPARE_TAG) && !hit_any && (miss_cnt != '1))
                miss_cnt <= miss_cnt + 1'b1;
            if ((state == FLUSH) && (flush_idx == IW'(SETS - 1)) && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

    assign bus.o_hit_cnt   = hit_cnt;
    assign bus.o_miss_cnt  = miss_cnt;
    assign bus.o_flush_cnt = flush_cnt;
`endif
endmodule

// File: tb/tb_icache_ctrl_nway.sv
// Directed bench for icache_ctrl_nway with WAYS=4, SETS=64, BEATS=8.
module tb_icache_ctrl_nway;
  localparam int WAYS  = 4;
  localparam int SETS  = 64;
  localparam int BEATS = 8;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CMP   = 3'd1;
  localparam logic [2:0] S_AREQ  = 3'd2;
  localparam logic [2:0] S_ALLOC = 3'd3;
  localparam logic [2:0] S_FLUSH = 3'd4;

  logic clk;
  logic arstn;
  int   total;
  int   bad;
  logic [1:0] exp_q[$];

  icache_ctrl_nway_if #(.WAYS(WAYS), .SETS(SETS), .BEATS(BEATS)) bus ();

  icache_ctrl_nway #(.WAYS(WAYS), .SETS(SETS), .BEATS(BEATS)) dut (
    .clk   (clk),
    .arstn (arstn),
    .bus   (bus.master)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    bus.i_start     = 1'b0;
    bus.i_flush     = 1'b0;
    bus.i_valid     = '0;
    bus.i_tag_match = '0;
    bus.i_arready   = 1'b0;
    bus.i_rvalid    = 1'b0;
    bus.i_r_last    = 1'b0;
  endtask

  task automatic test_reset;
    clear_inputs();
    arstn = 1'b0;
    tick();
    tick();
    total++;
    if ({bus.o_state, bus.o_stall, bus.o_busy, bus.o_arvalid, bus.o_rready, bus.o_fill_we,
         bus.o_fill_done, bus.o_refill_err, bus.o_inval_we, bus.o_hit}
        !== {S_IDLE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_outputs: state=%0d stall=%b busy=%b arvalid=%b rready=%b fill_we=%b done=%b err=%b inval=%b hit=%b",
               bus.o_state, bus.o_stall, bus.o_busy, bus.o_arvalid, bus.o_rready, bus.o_fill_we,
               bus.o_fill_done, bus.o_refill_err, bus.o_inval_we, bus.o_hit);
    end
    total++;
    if ({bus.o_beat_cnt, bus.o_inval_idx, bus.o_fill_way, bus.o_hit_way} !== 13'd0) begin
      bad++;
      $display("FAIL reset_counters: beat=%0d idx=%0d fill_way=%0d hit_way=%0d expected all 0",
               bus.o_beat_cnt, bus.o_inval_idx, bus.o_fill_way, bus.o_hit_way);
    end
    arstn = 1'b1;
    tick();
    total++;
    if (bus.o_state !== S_IDLE) begin
      bad++;
      $display("FAIL reset_idle_hold: state=%0d expected %0d", bus.o_state, S_IDLE);
    end
  endtask

  task automatic test_hit;
    bus.i_start = 1'b1;
    tick();
    bus.i_start     = 1'b0;
    bus.i_valid     = 4'b1111;
    bus.i_tag_match = 4'b0100;
    #1;
    total++;
    if ({bus.o_state, bus.o_hit, bus.o_hit_way, bus.o_stall} !== {S_CMP, 1'b1, 2'd2, 1'b0}) begin
      bad++;
      $display("FAIL hit_compare: state=%0d hit=%b way=%0d stall=%b expected state=1 hit=1 way=2 stall=0",
               bus.o_state, bus.o_hit, bus.o_hit_way, bus.o_stall);
    end
    tick();
    bus.i_tag_match = '0;
    #1;
    total++;
    if ({bus.o_state, bus.o_hit, bus.o_hit_way, bus.o_busy} !== {S_IDLE, 1'b0, 2'd0, 1'b0}) begin
      bad++;
      $display("FAIL hit_return: state=%0d hit=%b way=%0d busy=%b expected idle, no hit",
               bus.o_state, bus.o_hit, bus.o_hit_way, bus.o_busy);
    end
  endtask

  // One full miss: compare, address request with ar_wait stalled cycles,
  // nbeats read beats (last one flagged), optional flush pulse on flush_beat,
  // then the post-refill compare that hits in the refilled way.
  task automatic do_miss(input logic [3:0] valid, input int exp_victim,
                         input int ar_wait, input int nbeats, input int flush_beat);
    logic [3:0] tm;
    logic       last;
    logic       exp_err;
    bus.i_start = 1'b1;
    tick();
    bus.i_start     = 1'b0;
    bus.i_valid     = valid;
    bus.i_tag_match = 4'b0000;
    #1;
    total++;
    if ({bus.o_state, bus.o_hit, bus.o_stall} !== {S_CMP, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL miss_compare: state=%0d hit=%b stall=%b expected state=1 hit=0 stall=1",
               bus.o_state, bus.o_hit, bus.o_stall);
    end
    tick();
    for (int i = 0; i < ar_wait; i++) begin
      total++;
      if ({bus.o_state, bus.o_arvalid, bus.o_stall} !== {S_AREQ, 1'b1, 1'b1}) begin
        bad++;
        $display("FAIL arvalid_hold: cycle=%0d state=%0d arvalid=%b expected state=2 arvalid=1",
                 i, bus.o_state, bus.o_arvalid);
      end
      tick();
    end
    bus.i_arready = 1'b1;
    #1;
    total++;
    if ({bus.o_state, bus.o_arvalid} !== {S_AREQ, 1'b1}) begin
      bad++;
      $display("FAIL arvalid_accept: state=%0d arvalid=%b expected state=2 arvalid=1",
               bus.o_state, bus.o_arvalid);
    end
    tick();
    bus.i_arready = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      last          = (b == nbeats - 1);
      exp_err       = last && ((b % BEATS) != BEATS - 1);
      bus.i_rvalid  = 1'b1;
      bus.i_r_last  = last;
      bus.i_flush   = (b == flush_beat);
      #1;
      total++;
      if ({bus.o_state, bus.o_rready, bus.o_fill_we, bus.o_beat_cnt, bus.o_fill_way,
           bus.o_fill_done, bus.o_refill_err, bus.o_arvalid}
          !== {S_ALLOC, 1'b1, 1'b1, 3'(b % BEATS), 2'(exp_victim), last, exp_err, 1'b0}) begin
        bad++;
        $display("FAIL refill_beat %0d: state=%0d rready=%b we=%b beat=%0d way=%0d done=%b err=%b expected beat=%0d way=%0d done=%b err=%b",
                 b, bus.o_state, bus.o_rready, bus.o_fill_we, bus.o_beat_cnt, bus.o_fill_way,
                 bus.o_fill_done, bus.o_refill_err, b % BEATS, exp_victim, last, exp_err);
      end
      tick();
    end
    bus.i_rvalid    = 1'b0;
    bus.i_r_last    = 1'b0;
    bus.i_flush     = 1'b0;
    tm              = 4'b0001 << exp_victim;
    bus.i_valid     = 4'b1111;
    bus.i_tag_match = tm;
    #1;
    total++;
    if ({bus.o_state, bus.o_hit, bus.o_hit_way, bus.o_stall, bus.o_fill_way}
        !== {S_CMP, 1'b1, 2'(exp_victim), 1'b0, 2'(exp_victim)}) begin
      bad++;
      $display("FAIL post_refill_hit: state=%0d hit=%b way=%0d stall=%b fill_way=%0d expected way %0d",
               bus.o_state, bus.o_hit, bus.o_hit_way, bus.o_stall, bus.o_fill_way, exp_victim);
    end
    tick();
    bus.i_tag_match = '0;
  endtask

  task automatic test_miss_free;
    do_miss(4'b1011, 2, 2, 8, -1);
  endtask

  task automatic test_round_robin;
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd0);
    while (exp_q.size() > 0) begin
      do_miss(4'b1111, int'(exp_q.pop_front()), 0, 8, -1);
    end
  endtask

  task automatic test_short_burst;
    // pointer advanced five times above, so it now points at way 1
    do_miss(4'b1111, 1, 1, 5, -1);
  endtask

  task automatic test_flush;
    do_miss(4'b1110, 0, 0, 8, 3);
    bus.i_start = 1'b1;
    #1;
    total++;
    if ({bus.o_state, bus.o_busy, bus.o_inval_we} !== {S_IDLE, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL flush_deferred: state=%0d busy=%b inval=%b expected idle before walk",
               bus.o_state, bus.o_busy, bus.o_inval_we);
    end
    tick();
    for (int k = 0; k < SETS; k++) begin
      bus.i_flush = (k == 10);
      #1;
      total++;
      if ({bus.o_state, bus.o_inval_we, bus.o_inval_idx, bus.o_stall, bus.o_busy}
          !== {S_FLUSH, 1'b1, 6'(k), 1'b1, 1'b1}) begin
        bad++;
        $display("FAIL flush_walk %0d: state=%0d inval=%b idx=%0d stall=%b expected idx=%0d",
                 k, bus.o_state, bus.o_inval_we, bus.o_inval_idx, bus.o_stall, k);
      end
      tick();
    end
    bus.i_flush = 1'b0;
    #1;
    total++;
    if ({bus.o_state, bus.o_inval_we, bus.o_inval_idx} !== {S_IDLE, 1'b0, 6'd0}) begin
      bad++;
      $display("FAIL flush_end: state=%0d inval=%b idx=%0d expected idle, idx 0",
               bus.o_state, bus.o_inval_we, bus.o_inval_idx);
    end
    tick();
    bus.i_start     = 1'b0;
    bus.i_valid     = 4'b1111;
    bus.i_tag_match = 4'b1000;
    #1;
    total++;
    if ({bus.o_state, bus.o_hit, bus.o_hit_way} !== {S_CMP, 1'b1, 2'd3}) begin
      bad++;
      $display("FAIL start_after_flush: state=%0d hit=%b way=%0d expected state=1 hit=1 way=3",
               bus.o_state, bus.o_hit, bus.o_hit_way);
    end
    tick();
    bus.i_tag_match = '0;
    tick();
    total++;
    if ({bus.o_state, bus.o_inval_we} !== {S_IDLE, 1'b0}) begin
      bad++;
      $display("FAIL flush_absorbed: state=%0d inval=%b expected idle, no second walk",
               bus.o_state, bus.o_inval_we);
    end
    // walk cleared the round-robin pointer
    do_miss(4'b1111, 0, 0, 8, -1);
  endtask

  task automatic test_reset_mid_request;
    bus.i_start = 1'b1;
    tick();
    bus.i_start     = 1'b0;
    bus.i_valid     = 4'b1111;
    bus.i_tag_match = 4'b0000;
    tick();
    total++;
    if ({bus.o_state, bus.o_arvalid, bus.o_fill_way} !== {S_AREQ, 1'b1, 2'd1}) begin
      bad++;
      $display("FAIL pre_reset_request: state=%0d arvalid=%b victim=%0d expected state=2 arvalid=1 victim=1",
               bus.o_state, bus.o_arvalid, bus.o_fill_way);
    end
    arstn = 1'b0;
    #1;
    total++;
    if ({bus.o_state, bus.o_arvalid, bus.o_busy, bus.o_beat_cnt, bus.o_fill_way, bus.o_stall}
        !== {S_IDLE, 1'b0, 1'b0, 3'd0, 2'd0, 1'b1}) begin
      bad++;
      $display("FAIL async_reset: state=%0d arvalid=%b busy=%b beat=%0d victim=%0d stall=%b",
               bus.o_state, bus.o_arvalid, bus.o_busy, bus.o_beat_cnt, bus.o_fill_way, bus.o_stall);
    end
    tick();
    arstn = 1'b1;
    tick();
    do_miss(4'b1111, 0, 1, 8, -1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_hit();
    test_miss_free();
    test_round_robin();
    test_short_burst();
    test_flush();
    test_reset_mid_request();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/icache_ctrl_nway.md
Name: icache_ctrl_nway

Overview:
- Control FSM for an N-way set-associative instruction cache; next generation of the direct-mapped icache controller.
- Sits between the fetch stage and the tag/data arrays plus the AXI-style read channel.
- Adds:
  - per-way hit resolution;
  - victim selection (invalid-first, then round-robin);
  - explicit AR handshake;
  - refill beat counting;
  - a full-cache invalidate walk (fence.i).

Parameters:
- WAYS, 4, associativity; power of 2, ≥1.
- SETS, 64, number of sets; power of 2, ≥2.
- BEATS, 8, data beats per line refill; ≥1.

Ports:
- clk  in  1  clock.
- arstn  in  1  asynchronous active-low reset.
- i_start  in  1  fetch request; sampled in IDLE.
- i_flush  in  1  invalidate-all request (pulse or level).
- i_valid  in  WAYS  valid bit of each way at the current index.
- i_tag_match  in  WAYS  tag comparison result for each way.
- i_arready  in  1  read-address channel ready.
- i_rvalid  in  1  read-data beat valid.
- i_r_last  in  1  last read-data beat.
- o_stall  out  1  stall fetch.
- o_hit  out  1  cache hit (COMPARE_TAG only).
- o_hit_way  out  $clog2(WAYS) (min 1)  index of the hitting way.
- o_arvalid  out  1  read-address valid.
- o_rready  out  1  ready for read data.
- o_fill_we  out  1  write the current beat into the data array.
- o_fill_way  out  $clog2(WAYS) (min 1)  way being refilled.
- o_beat_cnt  out  $clog2(BEATS) (min 1)  word offset of the current beat.
- o_fill_done  out  1  one-cycle pulse: line complete; set valid and tag of o_fill_way.
- o_refill_err  out  1  one-cycle pulse: i_r_last arrived with beat count ≠ BEATS-1.
- o_inval_we  out  1  clear valid bits of all ways at o_inval_idx.
- o_inval_idx  out  $clog2(SETS)  set index being invalidated.
- o_busy  out  1  state ≠ IDLE.

Behaviour:
- States: IDLE, COMPARE_TAG, ADDR_REQ, ALLOCATE, FLUSH. All outputs are Moore/combinational from state, counters and inputs. No registered-output latency.
- Reset (async, arstn=0):
  - state := IDLE;
  - beat counter, flush index, round-robin pointer, flush-pending flag and victim register := 0.
  - Hence o_arvalid=0, o_rready=0, o_fill_we=0, o_inval_we=0, o_fill_done=0, o_refill_err=0, o_busy=0, o_stall=1.
  - A reset during ALLOCATE or FLUSH abandons the operation. There is no partial-line recovery, and the valid bit is never set.
- Hit logic: hit_vec = i_valid & i_tag_match; o_hit = |hit_vec in COMPARE_TAG. o_hit_way = lowest set bit of hit_vec. Multiple hits are illegal; the lowest index wins.
- IDLE:
  - o_stall=1.
  - If flush is pending or i_flush=1 → FLUSH (flush has priority over i_start).
  - Else if i_start → COMPARE_TAG.
- COMPARE_TAG:
  - Hit: o_stall=0 in the same cycle → IDLE.
  - Miss: o_stall=1. Victim register := lowest way with i_valid=0; if all ways are valid, victim := round-robin pointer, and the pointer increments modulo WAYS. → ADDR_REQ.
- ADDR_REQ:
  - o_arvalid=1, o_stall=1.
  - o_arvalid stays high until i_arready (no withdrawal).
  - On i_arready → ALLOCATE, beat counter := 0.
- ALLOCATE:
  - o_rready=1, o_stall=1, o_fill_way=victim.
  - Each cycle with i_rvalid: o_fill_we=1 at o_beat_cnt, then the counter increments.
  - i_rvalid with i_r_last:
    - o_fill_done=1 in that cycle;
    - o_refill_err=1 if o_beat_cnt ≠ BEATS-1;
    - → COMPARE_TAG, which re-checks and hits.
  - Beat counter wraps at BEATS-1 → 0 if i_r_last never arrives; the FSM waits for i_r_last.
- FLUSH:
  - o_inval_we=1, o_stall=1, o_inval_idx = flush index.
  - Index increments every cycle. At SETS-1: clear the pending flag, index := 0, round-robin pointer := 0 → IDLE.
  - Takes exactly SETS cycles.
- Flush arriving in COMPARE_TAG, ADDR_REQ or ALLOCATE: latched into the pending flag. The current miss/refill completes normally and returns to COMPARE_TAG → IDLE; flush then runs from IDLE. i_flush during FLUSH is absorbed.
- o_fill_way holds the victim register in all states. o_hit_way and o_hit are 0 outside COMPARE_TAG.

Optional Feature:
- Macro ICACHE_PERF_CNT_EN.
- Defined: adds
  - outputs o_hit_cnt [31:0], o_miss_cnt [31:0], o_flush_cnt [15:0];
  - increments on COMPARE_TAG hit (the first compare only, not the post-refill compare), COMPARE_TAG miss, and FLUSH completion;
  - counters saturate at all-ones and reset to 0.
- Undefined: these ports and registers do not exist. Core behaviour is identical.

Test Plan:
- Hit: WAYS=4, i_start, then i_valid=4'b1111, i_tag_match=4'b0100 → o_hit=1, o_hit_way=2, o_stall=0 one cycle after i_start; back in IDLE next cycle.
- Miss, invalid way free: i_valid=4'b1011, no match → victim 2; o_arvalid held 3 cycles until i_arready; then 8 rvalid beats with i_r_last on the 8th → o_fill_we with o_beat_cnt 0..7, o_fill_way=2, o_fill_done on beat 8, no o_refill_err.
- Round-robin: 5 consecutive misses with all ways valid → victims 0,1,2,3,0.
- Short burst: i_r_last on the 5th beat with BEATS=8 → o_refill_err=1 and o_fill_done=1 in the same cycle; FSM enters COMPARE_TAG.
- Flush: i_flush pulsed mid-ALLOCATE (SETS=64) → refill completes; then o_inval_we high for exactly 64 cycles with o_inval_idx 0..63; simultaneous i_start in IDLE waits until the flush finishes.
- Reset: arstn low during ADDR_REQ → o_arvalid=0 immediately, state IDLE, counters 0; after release, a new miss selects victim 0.
